// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encodings of the op select bit
//   mode_t          : per-beat mode bits that travel down the pipe with their operands
//   sat_value()     : clamp word for a saturating result (valid for widths up to MaxWidth)
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MaxWidth = 64;

  typedef struct packed {
    logic op;
    logic is_signed;
    logic sat;
  } mode_t;

  // Unsigned add clamps to all ones, unsigned sub to zero. Signed overflow always pushes the
  // true result in the direction of a's sign, so a_msb picks min (100..0) or max (011..1).
  // The low 'width' bits of the returned word hold the clamp value.
  function automatic logic [MaxWidth-1:0] sat_value(int unsigned width, logic is_signed,
                                                     logic a_msb, logic op);
    logic [MaxWidth-1:0] ones;
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] v;
    ones = {MaxWidth{1'b1}};
    mask = ones >> (MaxWidth - width);
    if (is_signed) begin
      v = a_msb ? (ones << (width - 1)) : (mask >> 1);
    end else begin
      v = (op == OP_SUB) ? '0 : mask;
    end
    return v & mask;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe.
//   master : operand producer + result consumer (drives in_valid, a, b, op, is_signed, sat,
//            out_ready)
//   slave  : the arithmetic unit (drives in_ready, out_valid, result, carry, ovf, zero, neg)
interface addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             is_signed;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, is_signed, sat, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, is_signed, sat, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit adder slice: s = x + y + cin.
//   x, y : operands (y is already inverted by the caller for subtraction)
//   cin  : carry in
//   s    : W-bit sum
//   cout : carry out of the slice
//   ovf  : two's-complement overflow, meaningful only on the most significant slice
module addsub_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);
  logic [W:0] full;

  always_comb begin
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    cout = full[W];
    ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  end
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with optional saturation and status flags.
// The carry chain is split: stage 1 adds the low LO_W bits, stage 2 adds the high bits using
// the registered mid carry and produces the registered result and flags.
// Throughput one beat per cycle; two beats in flight at most.
//   clk, rst : clock and synchronous active-high reset
//   bus      : addsub_if slave port (operand handshake in, result handshake out)
// WIDTH must match the interface WIDTH, be even, >= 4 and <= 64.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LO_W  = WIDTH / 2
) (
  input logic     clk,
  input logic     rst,
  addsub_if.slave bus
);
  localparam int unsigned HI_W = WIDTH - LO_W;

  typedef struct packed {
    logic [LO_W-1:0] lo_sum;
    logic            c_mid;
    logic [HI_W-1:0] a_hi;
    logic [HI_W-1:0] b_hi;  // already conditionally inverted
    mode_t           mode;
  } s1_payload_t;

  logic             s1_adv;
  logic             s2_adv;

  logic             s1_valid_q;
  s1_payload_t      s1_q;
  s1_payload_t      s1_d;

  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [WIDTH-1:0] b_eff;
  logic [LO_W-1:0]  lo_sum;
  logic             lo_cout;
  logic             lo_ovf_unused;

  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;
  logic             hi_sovf;

  logic [WIDTH-1:0] wrapped;
  logic [WIDTH-1:0] clamp;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             ovf_d;

  // Handshake: a stage may load when it is empty or its content moves on this edge.
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign bus.in_ready = s1_adv;

  // Stage 1: low slice
  assign b_eff = (bus.op == OP_ADD) ? bus.b : ~bus.b;

  addsub_slice #(
    .W (LO_W)
  ) u_lo (
    .x    (bus.a[LO_W-1:0]),
    .y    (b_eff[LO_W-1:0]),
    .cin  (bus.op),
    .s    (lo_sum),
    .cout (lo_cout),
    .ovf  (lo_ovf_unused)
  );

  always_comb begin
    s1_d                = '0;
    s1_d.lo_sum         = lo_sum;
    s1_d.c_mid          = lo_cout;
    s1_d.a_hi           = bus.a[WIDTH-1:LO_W];
    s1_d.b_hi           = b_eff[WIDTH-1:LO_W];
    s1_d.mode.op        = bus.op;
    s1_d.mode.is_signed = bus.is_signed;
    s1_d.mode.sat       = bus.sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2: high slice, flags, saturation
  addsub_slice #(
    .W (HI_W)
  ) u_hi (
    .x    (s1_q.a_hi),
    .y    (s1_q.b_hi),
    .cin  (s1_q.c_mid),
    .s    (hi_sum),
    .cout (hi_cout),
    .ovf  (hi_sovf)
  );

  always_comb begin
    wrapped  = {hi_sum, s1_q.lo_sum};
    // Subtraction reports borrow, the inverse of the adder carry-out.
    carry_d  = (s1_q.mode.op == OP_SUB) ? ~hi_cout : hi_cout;
    ovf_d    = s1_q.mode.is_signed ? hi_sovf : carry_d;
    clamp    = WIDTH'(sat_value(WIDTH, s1_q.mode.is_signed, s1_q.a_hi[HI_W-1], s1_q.mode.op));
    result_d = (s1_q.mode.sat && ovf_d) ? clamp : wrapped;
  end

  // Payload only loads with a real beat, so a stalled result never changes until retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
        zero_q   <= (result_d == '0);
        neg_q    <= result_d[WIDTH-1] & s1_q.mode.is_signed;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: one 8-bit and one 16-bit instance sharing a clock.
// Expected beats are queued on acceptance and compared when each result retires.
module tb_addsub_pipe;

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  typedef struct {
    int          sel;  // 0 = 8-bit unit, 1 = 16-bit unit
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        sgn;
    logic        sat;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t held[2];
  bit   held_v[2];
  bit   rnd_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_if #(.WIDTH(8))  if8 ();
  addsub_if #(.WIDTH(16)) if16 ();

  addsub_pipe #(.WIDTH(8), .LO_W(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  addsub_pipe #(.WIDTH(16), .LO_W(8)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference: plain integer arithmetic on the full-width values.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic sgn, input logic sat);
    longint mask, half, ua, ub, sa, sb, sres, res;
    logic   c, so, o;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    c    = op ? (ua < ub) : ((ua + ub) > mask);
    sres = op ? sa - sb : sa + sb;
    so   = (sres >= half) || (sres < -half);
    o    = sgn ? so : c;
    res  = (op ? ua - ub : ua + ub) & mask;
    if (sat && o) res = sgn ? ((sres < 0) ? half : half - 1) : (op ? 0 : mask);
    e.result = 16'(res);
    e.carry  = c;
    e.ovf    = o;
    e.zero   = (res == 0);
    e.neg    = sgn && (res >= half);
    return e;
  endfunction

  function automatic vec_t mk(input int sel, input logic [15:0] a, input logic [15:0] b,
                              input logic op, input logic sgn, input logic sat,
                              input logic [15:0] r, input logic c, input logic o,
                              input logic z, input logic n);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.op = op; v.sgn = sgn; v.sat = sat;
    v.e.result = r; v.e.carry = c; v.e.ovf = o; v.e.zero = z; v.e.neg = n;
    return v;
  endfunction

  // Offer one beat; returns just after the accepting edge with in_valid dropped, so a
  // following call re-asserts it before the next edge and no bubble is introduced.
  task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b, input logic op,
                      input logic sgn, input logic sat, input exp_t e);
    bit done;
    done = 0;
    if (sel == 0) begin
      if8.a = a[7:0]; if8.b = b[7:0]; if8.op = op; if8.is_signed = sgn; if8.sat = sat;
      if8.in_valid = 1'b1;
    end else begin
      if16.a = a; if16.b = b; if16.op = op; if16.is_signed = sgn; if16.sat = sat;
      if16.in_valid = 1'b1;
    end
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if ((sel == 0) ? if8.in_ready : if16.in_ready) begin
        if (sel == 0) q8.push_back(e);
        else q16.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (sel == 0) if8.in_valid = 1'b0;
    else if16.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: unit %0d got no in_ready, want in_ready=1", sel);
    end
  endtask

  task automatic mon(input int sel, input logic v, input logic r, input logic [15:0] res,
                     input logic c, input logic o, input logic z, input logic n);
    exp_t act, e;
    act.result = res; act.carry = c; act.ovf = o; act.zero = z; act.neg = n;
    if (v && !r) begin
      if (held_v[sel]) check($sformatf("stall_hold%0d", sel), 32'(act), 32'(held[sel]));
      held[sel]   = act;
      held_v[sel] = 1;
    end else begin
      held_v[sel] = 0;
    end
    if (v && r) begin
      if (((sel == 0) ? q8.size() : q16.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat%0d: got beat %h, want no beat", sel, act);
      end else begin
        if (sel == 0) e = q8.pop_front();
        else e = q16.pop_front();
        check($sformatf("beat%0d", sel), 32'(act), 32'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, if8.out_valid, if8.out_ready, {8'h00, if8.result}, if8.carry, if8.ovf, if8.zero,
          if8.neg);
      mon(1, if16.out_valid, if16.out_ready, if16.result, if16.carry, if16.ovf, if16.zero,
          if16.neg);
    end
  end

  task automatic drain(input int n);
    if8.out_ready  = 1'b1;
    if16.out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("drain8", q8.size(), 0);
    check("drain16", q16.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[13];
    int   t0;
    logic [15:0] ra, rb;
    logic rop, rsg, rsat;
    int   w;

    // sel, a, b, op, sgn, sat -> result, carry, ovf, zero, neg
    tab[0]  = mk(0, 16'h0003, 16'h0001, 1, 0, 0, 16'h0002, 0, 0, 0, 0);
    tab[1]  = mk(0, 16'h00F8, 16'h0002, 1, 1, 0, 16'h00F6, 0, 0, 0, 1);
    tab[2]  = mk(0, 16'h0081, 16'h0081, 1, 1, 0, 16'h0000, 0, 0, 1, 0);
    tab[3]  = mk(0, 16'h0005, 16'h0007, 1, 0, 1, 16'h0000, 1, 1, 1, 0);
    tab[4]  = mk(0, 16'h007F, 16'h0001, 0, 1, 1, 16'h007F, 0, 1, 0, 0);
    tab[5]  = mk(0, 16'h0080, 16'h0001, 1, 1, 1, 16'h0080, 0, 1, 0, 1);
    tab[6]  = mk(1, 16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 0, 0, 0, 0);
    tab[7]  = mk(1, 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 1, 1, 0);
    tab[8]  = mk(0, 16'h00FF, 16'h0001, 0, 0, 1, 16'h00FF, 1, 1, 0, 0);
    tab[9]  = mk(0, 16'h0080, 16'h0080, 0, 1, 1, 16'h0080, 1, 1, 0, 1);
    tab[10] = mk(0, 16'h007F, 16'h00FF, 1, 1, 1, 16'h007F, 1, 1, 0, 0);
    tab[11] = mk(1, 16'h8000, 16'h0001, 1, 1, 0, 16'h7FFF, 0, 1, 0, 0);
    tab[12] = mk(1, 16'h1234, 16'h1234, 1, 0, 0, 16'h0000, 0, 0, 1, 0);

    rst = 1'b1;
    if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.op = 0; if8.is_signed = 0; if8.sat = 0;
    if16.in_valid = 0; if16.a = 0; if16.b = 0; if16.op = 0; if16.is_signed = 0; if16.sat = 0;
    if8.out_ready = 1; if16.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid8", if8.out_valid, 0);
    check("rst_result8", {if8.result, if8.carry, if8.ovf, if8.zero, if8.neg}, 0);
    check("rst_in_ready8", if8.in_ready, 1);
    check("rst_out_valid16", if16.out_valid, 0);
    check("rst_result16", {if16.result, if16.carry, if16.ovf, if16.zero, if16.neg}, 0);
    check("rst_in_ready16", if16.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      send(tab[i].sel, tab[i].a, tab[i].b, tab[i].op, tab[i].sgn, tab[i].sat, tab[i].e);
    end
    drain(6);

    // Latency: two register stages, so the result is presented after the edge following
    // the accepting edge.
    send(0, 16'h0003, 16'h0001, 1, 0, 0, model(8, 16'h0003, 16'h0001, 1, 0, 0));
    @(negedge clk);
    check("latency_early", if8.out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("latency_due", if8.out_valid, 1);
    @(posedge clk);
    #1;
    drain(4);

    // Full throughput with out_ready high: one accept per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      ra = 16'(i * 37); rb = 16'(i * 11 + 5);
      send(0, ra, rb, i[0], i[1], i[2], model(8, ra, rb, i[0], i[1], i[2]));
    end
    check("throughput_cycles", cyc - t0, 8);
    drain(4);

    // Backpressure: two beats fill the pipe, in_ready must drop, later beats wait.
    if8.out_ready = 1'b0;
    send(0, 16'h0010, 16'h0020, 0, 0, 0, model(8, 16'h0010, 16'h0020, 0, 0, 0));
    send(0, 16'h00F0, 16'h0020, 0, 0, 1, model(8, 16'h00F0, 16'h0020, 0, 0, 1));
    @(negedge clk);
    check("bp_in_ready_low", if8.in_ready, 0);
    @(posedge clk);
    #1;
    fork
      begin
        send(0, 16'h0040, 16'h0050, 1, 1, 1, model(8, 16'h0040, 16'h0050, 1, 1, 1));
        send(0, 16'h0090, 16'h0070, 1, 1, 0, model(8, 16'h0090, 16'h0070, 1, 1, 0));
      end
      begin
        repeat (2) @(posedge clk);
        #1 if8.out_ready = 1'b1;
      end
    join
    drain(6);

    // Reset with two beats in flight: both discarded.
    if8.out_ready = 1'b0;
    send(0, 16'h0001, 16'h0002, 0, 0, 0, model(8, 16'h0001, 16'h0002, 0, 0, 0));
    send(0, 16'h0003, 16'h0004, 0, 0, 0, model(8, 16'h0003, 16'h0004, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q8.delete();
    @(negedge clk);
    check("flush_out_valid", if8.out_valid, 0);
    check("flush_in_ready", if8.in_ready, 1);
    @(posedge clk);
    #1;
    drain(6);

    // Random regression on both widths with random output stalls and input gaps.
    for (int sel = 0; sel < 2; sel++) begin
      w = (sel == 0) ? 8 : 16;
      rnd_busy = 1;
      fork
        begin
          for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            if (w == 8) begin
              ra = ra & 16'h00FF;
              rb = rb & 16'h00FF;
            end
            rop  = 1'($urandom_range(0, 1));
            rsg  = 1'($urandom_range(0, 1));
            rsat = 1'($urandom_range(0, 1));
            send(sel, ra, rb, rop, rsg, rsat, model(w, ra, rb, rop, rsg, rsat));
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
          end
          rnd_busy = 0;
        end
        begin
          while (rnd_busy) begin
            @(posedge clk);
            #1;
            if (sel == 0) if8.out_ready = 1'($urandom_range(0, 1));
            else if16.out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      drain(8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
